// File: rtl/serial_mag_comparator.sv
// ---------------------------------------------------------------------------
// serial_mag_comparator
//
// Bit-serial, MSB-first unsigned magnitude comparator. A compare is started
// with a start pulse; the operands are captured into shadow registers and
// examined one bit per cycle from the MSB down. The scan stops at the first
// differing bit, so latency depends on the operands (1..WIDTH cycles).
//
// Handshake: start is accepted on a rising edge whenever busy=0 (IDLE or
// DONE state). busy is high for the whole SCAN phase. done is a one-cycle
// pulse in the DONE state, during which out is valid and newly updated.
// start seen while busy=1 is ignored. A and B are only sampled on the
// accepting edge.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   compare request
//   A, B      in   WIDTH-bit unsigned operands
//   busy      out  compare in progress (SCAN)
//   done      out  single-cycle result-valid pulse
//   out       out  {gt, eq, lt}; 000 only after reset
//   dbg_state out  current FSM state (0 IDLE, 1 SCAN, 2 DONE)
// ---------------------------------------------------------------------------
module serial_mag_comparator #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [2:0]       out,
   output logic [1:0]       dbg_state
);

   localparam int IDXW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [IDXW-1:0]   r_idx;
   logic [2:0]        r_out;

   logic              w_accept;
   logic              w_bit_a;
   logic              w_bit_b;
   logic              w_step;
   logic              w_out_load;
   logic [2:0]        w_out_next;

   assign w_bit_a  = r_a[r_idx];
   assign w_bit_b  = r_b[r_idx];
   // A new compare can start from IDLE or straight out of DONE.
   assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   // Bits tie and lower bits remain: move to the next lower bit.
   assign w_step   = (r_state == S_SCAN) && (w_bit_a == w_bit_b) &&
                     (r_idx != '0);

   always_comb begin
      w_next_state = r_state;
      w_out_load   = 1'b0;
      w_out_next   = r_out;
      case (r_state)
         S_IDLE: begin
            if (start) w_next_state = S_SCAN;
         end
         S_SCAN: begin
            if (w_bit_a && !w_bit_b) begin
               w_out_load   = 1'b1;
               w_out_next   = 3'b100;
               w_next_state = S_DONE;
            end else if (!w_bit_a && w_bit_b) begin
               w_out_load   = 1'b1;
               w_out_next   = 3'b001;
               w_next_state = S_DONE;
            end else if (r_idx == '0) begin
               w_out_load   = 1'b1;
               w_out_next   = 3'b010;
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            w_next_state = start ? S_SCAN : S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_idx <= '0;
      end else if (w_accept) begin
         r_a   <= A;
         r_b   <= B;
         r_idx <= IDXW'(WIDTH - 1);
      end else if (w_step) begin
         r_idx <= r_idx - 1'b1;
      end
   end

   // out only moves on the edge entering DONE; it holds through IDLE/SCAN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= 3'b000;
      end else if (w_out_load) begin
         r_out <= w_out_next;
      end
   end

   assign busy      = (r_state == S_SCAN);
   assign done      = (r_state == S_DONE);
   assign out       = r_out;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// ---------------------------------------------------------------------------
// tb_serial_mag_comparator
//
// Bench for serial_mag_comparator. The reference model computes the result
// from unsigned arithmetic and the latency from the position of the highest
// set bit of A^B.
// ---------------------------------------------------------------------------
module tb_serial_mag_comparator;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [2:0]       out;
   logic [1:0]       dbg_state;

   int checks = 0;
   int errors = 0;

   serial_mag_comparator #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .A         (A),
      .B         (B),
      .busy      (busy),
      .done      (done),
      .out       (out),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [2:0] model_res(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
      if (a > b) return 3'b100;
      if (a < b) return 3'b001;
      return 3'b010;
   endfunction

   // Cycles from the accepting edge to the edge that raises done.
   function automatic int model_lat(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
      int d;
      int msb;
      d = int'(a ^ b);
      if (d == 0) return WIDTH;
      msb = $clog2(d + 1) - 1;
      return WIDTH - msb;
   endfunction

   // ---------------- driver ----------------
   // Issues one compare and observes it until done (bounded). busy_cnt
   // counts the post-edge samples with busy=1 from E0 up to done.
   task automatic do_compare(input  logic [WIDTH-1:0] a,
                             input  logic [WIDTH-1:0] b,
                             output int               lat,
                             output logic [2:0]       res,
                             output int               busy_cnt,
                             output logic             busy_at_done);
      @(negedge clk);
      start = 1'b1;
      A     = a;
      B     = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      A     = WIDTH'($urandom);
      B     = WIDTH'($urandom);
      lat          = -1;
      res          = 3'bxxx;
      busy_cnt     = 0;
      busy_at_done = 1'b1;
      if (busy) busy_cnt++;
      for (int n = 1; n <= WIDTH + 2; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat          = n;
            res          = out;
            busy_at_done = busy;
            break;
         end
         if (busy) busy_cnt++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      A     = '0;
      B     = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (out !== 3'b000) begin errors++; $display("FAIL reset_out got=%b exp=000", out); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", busy, done); end
   endtask

   task automatic test_directed();
      logic [WIDTH-1:0] ta[7] = '{8'd25, 8'd5,  8'd15, 8'd255, 8'd0,   8'd128, 8'd0};
      logic [WIDTH-1:0] tb[7] = '{8'd10, 8'd20, 8'd15, 8'd0,   8'd255, 8'd0,   8'd1};
      int lat; logic [2:0] res; int bc; logic bd;
      for (int i = 0; i < 7; i++) begin
         do_compare(ta[i], tb[i], lat, res, bc, bd);
         checks++; if (lat != model_lat(ta[i], tb[i])) begin errors++; $display("FAIL dir_lat A=%0d B=%0d got=%0d exp=%0d", ta[i], tb[i], lat, model_lat(ta[i], tb[i])); end
         checks++; if (res !== model_res(ta[i], tb[i])) begin errors++; $display("FAIL dir_out A=%0d B=%0d got=%b exp=%b", ta[i], tb[i], res, model_res(ta[i], tb[i])); end
         checks++; if (bc != model_lat(ta[i], tb[i])) begin errors++; $display("FAIL dir_busy_cycles A=%0d B=%0d got=%0d exp=%0d", ta[i], tb[i], bc, model_lat(ta[i], tb[i])); end
         checks++; if (bd !== 1'b0) begin errors++; $display("FAIL dir_busy_at_done got=%b exp=0", bd); end
         // one cycle later: back in IDLE, done gone, result held
         @(posedge clk);
         #1;
         checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL dir_idle busy=%b done=%b exp=0/0", busy, done); end
         checks++; if (out !== model_res(ta[i], tb[i])) begin errors++; $display("FAIL dir_out_hold got=%b exp=%b", out, model_res(ta[i], tb[i])); end
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] a, b;
      int lat; logic [2:0] res; int bc; logic bd;
      for (int i = 0; i < 40; i++) begin
         a = WIDTH'($urandom);
         // bias some cases toward equal or near-equal operands
         case ($urandom_range(3, 0))
            0: b = a;
            1: b = a ^ WIDTH'(1 << $urandom_range(WIDTH - 1, 0));
            default: b = WIDTH'($urandom);
         endcase
         do_compare(a, b, lat, res, bc, bd);
         checks++; if (lat != model_lat(a, b)) begin errors++; $display("FAIL rnd_lat A=%0d B=%0d got=%0d exp=%0d", a, b, lat, model_lat(a, b)); end
         checks++; if (res !== model_res(a, b)) begin errors++; $display("FAIL rnd_out A=%0d B=%0d got=%b exp=%b", a, b, res, model_res(a, b)); end
         checks++; if (bc != model_lat(a, b)) begin errors++; $display("FAIL rnd_busy_cycles A=%0d B=%0d got=%0d exp=%0d", a, b, bc, model_lat(a, b)); end
         // random idle gap of 0..2 cycles; 0 gives a back-to-back issue
         repeat ($urandom_range(2, 0)) @(posedge clk);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      start = 1'b1;
      A = 8'd255;
      B = 8'd0;
      @(posedge clk);  // E0
      #1;
      A = 8'd0;
      B = 8'd255;     // start stays high through SCAN and DONE
      @(posedge clk);  // E1
      #1;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got=%b exp=1", done); end
      checks++; if (out !== 3'b100) begin errors++; $display("FAIL b2b_out1 got=%b exp=100", out); end
      @(posedge clk);  // E2: second compare accepted
      #1;
      start = 1'b0;
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b done=%b exp=1/0", busy, done); end
      checks++; if (out !== 3'b100) begin errors++; $display("FAIL b2b_out_hold_scan got=%b exp=100", out); end
      @(posedge clk);  // E3
      #1;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got=%b exp=1", done); end
      checks++; if (out !== 3'b001) begin errors++; $display("FAIL b2b_out2 got=%b exp=001", out); end
      @(posedge clk);
      #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle busy=%b done=%b exp=0/0", busy, done); end
   endtask

   task automatic test_start_while_busy();
      int lat = -1;
      @(negedge clk);
      start = 1'b1;
      A = 8'd200;
      B = 8'd201;     // differ only at bit 0: 8-cycle scan
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int n = 1; n <= WIDTH + 2; n++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
         if (n == 1 || n == 3 || n == 5) begin
            start = 1'b1;
            A = 8'd255;
            B = 8'd0;
         end
      end
      checks++; if (lat != model_lat(8'd200, 8'd201)) begin errors++; $display("FAIL busy_start_lat got=%0d exp=%0d", lat, model_lat(8'd200, 8'd201)); end
      checks++; if (out !== model_res(8'd200, 8'd201)) begin errors++; $display("FAIL busy_start_out got=%b exp=%b", out, model_res(8'd200, 8'd201)); end
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL busy_start_no_restart busy=%b done=%b exp=0/0", busy, done); end
   endtask

   task automatic test_reset_mid_scan();
      int lat; logic [2:0] res; int bc; logic bd;
      int spurious = 0;
      @(negedge clk);
      start = 1'b1;
      A = 8'd15;
      B = 8'd15;
      @(posedge clk);  // E0
      #1;
      start = 1'b0;
      @(posedge clk);  // E1
      @(posedge clk);  // E2
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got=%b exp=0", done); end
      checks++; if (out !== 3'b000) begin errors++; $display("FAIL rst_mid_out got=%b exp=000", out); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < WIDTH + 2; n++) begin
         @(posedge clk);
         #1;
         if (done || busy) spurious++;
      end
      checks++; if (spurious != 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d exp=0", spurious); end
      checks++; if (out !== 3'b000) begin errors++; $display("FAIL rst_mid_out_stays got=%b exp=000", out); end
      do_compare(8'd25, 8'd10, lat, res, bc, bd);
      checks++; if (lat != model_lat(8'd25, 8'd10)) begin errors++; $display("FAIL rst_mid_new_lat got=%0d exp=%0d", lat, model_lat(8'd25, 8'd10)); end
      checks++; if (res !== model_res(8'd25, 8'd10)) begin errors++; $display("FAIL rst_mid_new_out got=%b exp=%b", res, model_res(8'd25, 8'd10)); end
   endtask

   // ---------------- done-pulse monitor ----------------
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_done && done) begin
            errors++;
            $display("FAIL done_two_cycles got=1 exp=0");
         end
      end
      prev_done <= done;
   end

   // ---------------- sequence ----------------
   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_start_while_busy();
      test_reset_mid_scan();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
